cal_seq_ctrl: RTL and testbench
===============================

Name: cal_seq_ctrl

Overview:
- Sequencer for the 6-bit calibration-parameter holding register, which captures cal_para on a one-cycle cal_load strobe.
- Runs a successive-approximation (SAR) search: drive a trial code, load it, wait for the analog path to settle, sample a comparator, then decide the bit.
- Also arbitrates a host direct-write path into the same register.
- Sits between the host/config logic and the cal_load register; all outputs are registered.

Parameters:
WIDTH, 6, calibration code width
SETTLE, 16, settle cycles after each cal_load pulse before sampling cmp_in (legal range 1..255)
CNT_W, 8, settle counter width

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin SAR calibration; level sampled in IDLE only
abort  in  1  cancel a running calibration
cmp_in  in  1  comparator result: 1 = keep the trial bit, 0 = clear it
host_wr  in  1  host direct-write request
host_para  in  WIDTH  host code
cal_load  out  1  one-cycle load strobe to the holding register
cal_para  out  WIDTH  code presented with cal_load
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a calibration completes
sat  out  1  valid with done: result is all-zeros or all-ones
cal_result  out  WIDTH  last completed calibration code

Behaviour:
- Reset (async, rst=1): state IDLE; cal_load=0, cal_para=0, busy=0, done=0, sat=0, cal_result=0, bit index=WIDTH-1, settle counter=0.
- States: IDLE, LOAD, SETTLE, SAMPLE, FINAL, RESTORE.
- IDLE, start=1: trial = 1<<(WIDTH-1), idx = WIDTH-1, go to LOAD. start takes priority over host_wr; a host_wr in the same cycle is dropped.
- IDLE, host_wr=1 and start=0: next cycle cal_para=host_para and cal_load=1 for one cycle. Stay in IDLE. cal_result unchanged. No busy, no done.
- LOAD: cal_para=trial, cal_load=1 for exactly one cycle; counter cleared; go to SETTLE.
- SETTLE: counter increments each cycle; after SETTLE cycles in this state go to SAMPLE.
- SAMPLE: cmp_in sampled this cycle. If cmp_in=0, clear trial[idx].
  - idx=0: go to FINAL.
  - else: idx-1, set trial[idx-1], go to LOAD.
- FINAL (one cycle):
  - cal_para = final trial, cal_load=1.
  - cal_result = trial, done=1.
  - sat=1 if trial==0 or trial==all-ones, else 0.
  - Go to IDLE.
- Latency: start sampled at edge N; first cal_load is high in cycle N+1. Each bit takes SETTLE+2 cycles. done is high in cycle N+1+WIDTH*(SETTLE+2). With the defaults that is 109 cycles after start.
- cal_load is high only in LOAD, FINAL, RESTORE and the host-write cycle; never two consecutive cycles except FINAL→host write is impossible (host ignored in FINAL).
- host_wr while busy=1: ignored, no queuing.
- abort in LOAD/SETTLE/SAMPLE: go to RESTORE. abort takes priority over any SAMPLE decision.
- RESTORE: cal_para=cal_result (previous good code), cal_load=1 for one cycle; done=0, cal_result unchanged; go to IDLE.
- abort in IDLE or FINAL: ignored; FINAL completes normally.
- start held high: a new calibration begins in the cycle after returning to IDLE (back-to-back runs are legal).
- rst asserted mid-run: immediate return to reset values; no RESTORE strobe is issued.
- done and sat are pulses; sat=0 whenever done=0.

Test Plan:
- Reset: assert rst mid-SETTLE → all outputs 0 and state IDLE immediately. After release, no cal_load until start.
- SAR convergence: SETTLE=4; model cmp_in = (latched code <= 37); pulse start → cal_load pulses carry 32,48,40,36,38,37, then final 37. done in cycle 37 after start, cal_result=37, sat=0.
- Saturation: cmp_in tied 1 → result 63, sat=1. cmp_in tied 0 → result 0, sat=1.
- Host path: in IDLE, host_wr with host_para=21 → one-cycle cal_load with cal_para=21, busy stays 0. host_wr during SETTLE → no cal_load, run unaffected.
- Abort: cal_result=37 from a prior run; start, abort during second SETTLE → RESTORE cal_load with cal_para=37, no done, then IDLE with cal_result=37.
- Simultaneous: start and host_wr=1 (host_para=5) in the same cycle → calibration runs (first cal_para=32); code 5 never loaded.

Source files
------------

// File: rtl/cal_seq_ctrl.sv
// rtl/cal_seq_ctrl.sv - SAR calibration sequencer and host-write arbiter for the cal_load holding register
// All outputs are registered; abort restores the last good code.
module cal_seq_ctrl #(
   parameter int WIDTH  = 6,
   parameter int SETTLE = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_in,
   input  logic             host_wr,
   input  logic [WIDTH-1:0] host_para,
   output logic             cal_load,
   output logic [WIDTH-1:0] cal_para,
   output logic             busy,
   output logic             done,
   output logic             sat,
   output logic [WIDTH-1:0] cal_result
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] TOP   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES  = '1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_FINAL, S_RESTORE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] trial;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] trial_dec;
   logic [WIDTH-1:0] trial_next;

   // trial_dec: current bit decided; trial_next: also sets the next lower trial bit
   always_comb begin
      bit_mask   = WIDTH'(1) << idx;
      trial_dec  = cmp_in ? trial : (trial & ~bit_mask);
      trial_next = trial_dec | (bit_mask >> 1);
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         trial      <= '0;
         idx        <= IDX_TOP;
         cnt        <= '0;
         cal_load   <= 1'b0;
         cal_para   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sat        <= 1'b0;
         cal_result <= '0;
      end else begin
         cal_load <= 1'b0;
         done     <= 1'b0;
         sat      <= 1'b0;
         if (abort && (state inside {S_LOAD, S_SETTLE, S_SAMPLE})) begin
            state    <= S_RESTORE;
            cal_para <= cal_result;
            cal_load <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     trial    <= TOP;
                     idx      <= IDX_TOP;
                     cal_para <= TOP;
                     cal_load <= 1'b1;
                     busy     <= 1'b1;
                     state    <= S_LOAD;
                  end else if (host_wr) begin
                     cal_para <= host_para;
                     cal_load <= 1'b1;
                  end
               end
               S_LOAD: begin
                  cnt   <= '0;
                  state <= S_SETTLE;
               end
               S_SETTLE: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == SETTLE_LAST) state <= S_SAMPLE;
               end
               S_SAMPLE: begin
                  cal_load <= 1'b1;
                  if (idx == '0) begin
                     trial      <= trial_dec;
                     cal_para   <= trial_dec;
                     cal_result <= trial_dec;
                     done       <= 1'b1;
                     sat        <= (trial_dec == '0) || (trial_dec == ONES);
                     state      <= S_FINAL;
                  end else begin
                     trial    <= trial_next;
                     cal_para <= trial_next;
                     idx      <= idx - 1'b1;
                     state    <= S_LOAD;
                  end
               end
               S_FINAL, S_RESTORE: begin
                  idx   <= IDX_TOP;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cal_seq_ctrl.sv
// tb/tb_cal_seq_ctrl.sv - randomized self-checking bench for cal_seq_ctrl against a SAR search model
// The model derives the trial-code sequence from a comparator threshold with plain arithmetic.
module tb_cal_seq_ctrl;

   localparam int W = 6;
   localparam int S = 4;
   localparam int RUN_CYC = 1 + W * (S + 2);

   logic         clk_sys = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         cmp_in = 1'b0;
   logic         host_wr = 1'b0;
   logic [W-1:0] host_para = '0;
   logic         cal_load;
   logic [W-1:0] cal_para;
   logic         busy;
   logic         done;
   logic         sat;
   logic [W-1:0] cal_result;

   int total = 0;
   int bad = 0;
   int exp_result = 0;

   cal_seq_ctrl #(.WIDTH(W), .SETTLE(S), .CNT_W(8)) dut (
      .clk_sys(clk_sys), .rst(rst), .start(start), .abort(abort), .cmp_in(cmp_in),
      .host_wr(host_wr), .host_para(host_para), .cal_load(cal_load), .cal_para(cal_para),
      .busy(busy), .done(done), .sat(sat), .cal_result(cal_result)
   );

   always #5 clk_sys = ~clk_sys;

   // comparator keeps a trial code when code <= thr; thr = -1 means it never keeps
   task automatic build_model(input int thr, output int codes[W+1]);
      int res = 0;
      for (int b = W - 1; b >= 0; b--) begin
         int code = res | (1 << b);
         codes[W-1-b] = code;
         if (code <= thr) res = code;
      end
      codes[W] = res;
   endtask

   task automatic run_cal(input int thr, input bit host_mid, input bit host_with_start,
                          input bit hold_start);
      int exp[W+1];
      int k = 0;
      int n = 1;
      int last = 0;
      bit got = 0;
      build_model(thr, exp);
      @(negedge clk_sys);
      start = 1'b1;
      if (host_with_start) begin host_wr = 1'b1; host_para = 5; end
      @(negedge clk_sys);
      start = hold_start;
      host_wr = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %0b want 1", busy); end
      while (!got && n <= 400) begin
         if (host_mid && n == 3) begin host_wr = 1'b1; host_para = W'($urandom); end
         else host_wr = 1'b0;
         if (cal_load) begin
            total++;
            if (k > W || cal_para !== W'(exp[k])) begin
               bad++;
               $display("FAIL load_seq[%0d] thr=%0d: got %0d want %0d", k, thr, cal_para,
                        (k > W) ? -1 : exp[k]);
            end
            last = int'(cal_para);
            k++;
         end
         cmp_in = (last <= thr);
         if (done) begin
            got = 1;
            total++;
            if (n != RUN_CYC) begin bad++; $display("FAIL done_cycle: got %0d want %0d", n, RUN_CYC); end
            total++;
            if (cal_result !== W'(exp[W])) begin
               bad++; $display("FAIL cal_result thr=%0d: got %0d want %0d", thr, cal_result, exp[W]);
            end
            total++;
            if (sat !== (exp[W] == 0 || exp[W] == (1 << W) - 1)) begin
               bad++; $display("FAIL sat thr=%0d: got %0b want %0b", thr, sat, (exp[W] == 0 || exp[W] == (1 << W) - 1));
            end
            total++;
            if (k != W + 1) begin bad++; $display("FAIL load_count: got %0d want %0d", k, W + 1); end
         end else if (sat) begin
            total++; bad++; $display("FAIL sat_without_done: got 1 want 0");
         end
         if (!got) begin @(negedge clk_sys); n++; end
      end
      host_wr = 1'b0;
      if (!got) begin total++; bad++; $display("FAIL done_timeout: got none want done"); end
      else exp_result = exp[W];
      @(negedge clk_sys);
      total++;
      if (busy !== 1'b0 || cal_load !== 1'b0) begin
         bad++; $display("FAIL after_final: got busy=%0b load=%0b want 0 0", busy, cal_load);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_sys);
      total++;
      if ({cal_load, cal_para, busy, done, sat, cal_result} !== '0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0", {cal_load, cal_para, busy, done, sat, cal_result});
      end
      rst = 1'b0;
      @(negedge clk_sys);
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      repeat (3) @(negedge clk_sys);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({cal_load, cal_para, busy, done, sat, cal_result} !== '0) begin
         bad++; $display("FAIL async_reset_mid_settle: got %h want 0", {cal_load, cal_para, busy, done, sat, cal_result});
      end
      @(negedge clk_sys);
      rst = 1'b0;
      begin
         int loads = 0;
         int busies = 0;
         repeat (12) begin
            @(negedge clk_sys);
            loads += cal_load;
            busies += busy;
         end
         total++;
         if (loads != 0 || busies != 0) begin
            bad++; $display("FAIL idle_after_reset: got loads=%0d busy=%0d want 0 0", loads, busies);
         end
      end
      exp_result = 0;
   endtask

   task automatic test_host();
      @(negedge clk_sys);
      host_wr = 1'b1;
      host_para = 21;
      @(negedge clk_sys);
      host_wr = 1'b0;
      total++;
      if (cal_load !== 1'b1 || cal_para !== W'(21) || busy !== 1'b0) begin
         bad++; $display("FAIL host_write: got load=%0b para=%0d busy=%0b want 1 21 0", cal_load, cal_para, busy);
      end
      total++;
      if (cal_result !== W'(exp_result) || done !== 1'b0) begin
         bad++; $display("FAIL host_result: got %0d done=%0b want %0d 0", cal_result, done, exp_result);
      end
      @(negedge clk_sys);
      total++;
      if (cal_load !== 1'b0) begin bad++; $display("FAIL host_one_cycle: got %0b want 0", cal_load); end
   endtask

   task automatic test_sar_convergence();
      run_cal(37, 1'b0, 1'b0, 1'b0);
      repeat (4) run_cal(int'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_saturation();
      run_cal(63, 1'b0, 1'b0, 1'b0);
      run_cal(-1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_host_busy();
      repeat (2) run_cal(int'($urandom_range(1, 62)), 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_simultaneous();
      run_cal(int'($urandom_range(0, 63)), 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_abort();
      int exp2[W+1];
      int thr2 = int'($urandom_range(0, 63));
      int last = 0;
      int dones = 0;
      run_cal(37, 1'b0, 1'b0, 1'b0);
      build_model(thr2, exp2);
      @(negedge clk_sys);
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         abort = (n == 9);
         if (cal_load) last = int'(cal_para);
         cmp_in = (last <= thr2);
         dones += done;
         if (n == 7) begin
            total++;
            if (cal_load !== 1'b1 || cal_para !== W'(exp2[1])) begin
               bad++; $display("FAIL abort_second_load: got %0b/%0d want 1/%0d", cal_load, cal_para, exp2[1]);
            end
         end
         if (n == 10) begin
            total++;
            if (cal_load !== 1'b1 || cal_para !== W'(37) || busy !== 1'b1) begin
               bad++; $display("FAIL restore_strobe: got load=%0b para=%0d busy=%0b want 1 37 1", cal_load, cal_para, busy);
            end
         end
         if (n == 11) begin
            total++;
            if (cal_load !== 1'b0 || busy !== 1'b0 || cal_result !== W'(37)) begin
               bad++; $display("FAIL after_restore: got load=%0b busy=%0b result=%0d want 0 0 37", cal_load, busy, cal_result);
            end
         end
         @(negedge clk_sys);
      end
      abort = 1'b0;
      total++;
      if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
   endtask

   task automatic test_back_to_back();
      run_cal(int'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b1);
      @(negedge clk_sys);
      total++;
      if (cal_load !== 1'b1 || cal_para !== W'(1 << (W - 1)) || busy !== 1'b1) begin
         bad++; $display("FAIL back_to_back_restart: got load=%0b para=%0d busy=%0b want 1 32 1", cal_load, cal_para, busy);
      end
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk_sys);
      abort = 1'b0;
      total++;
      if (cal_load !== 1'b1 || cal_para !== W'(exp_result)) begin
         bad++; $display("FAIL abort_in_load: got %0b/%0d want 1/%0d", cal_load, cal_para, exp_result);
      end
      repeat (2) @(negedge clk_sys);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL back_to_back_idle: got %0b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_host();
      test_sar_convergence();
      test_saturation();
      test_host_busy();
      test_simultaneous();
      test_abort();
      test_back_to_back();
      test_host();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
